// File: rtl/sv_ptw_tlb.sv
// Page-table walker with a fully associative, ASID-tagged TLB.
// Translates one request at a time and walks LEVELS levels through a single PTE read port.
`timescale 1ns/1ps
module sv_ptw_tlb #(
   parameter int LEVELS      = 2,
   parameter int VPN_W       = 10,
   parameter int PPN_W       = 20,
   parameter int TLB_ENTRIES = 8,
   parameter int ASID_W      = 9,
   localparam int VA_W       = 12 + LEVELS*VPN_W,
   localparam int PA_W       = 12 + PPN_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [VA_W-1:0]   req_vaddr,
   input  logic [1:0]        req_type,
   input  logic              satp_mode,
   input  logic [ASID_W-1:0] satp_asid,
   input  logic [PPN_W-1:0]  satp_ppn,
   input  logic [1:0]        priv,
   input  logic              mprv,
   input  logic              sum,
   input  logic              mxr,
   input  logic [1:0]        mpp,
   output logic              resp_valid,
   output logic [PA_W-1:0]   resp_paddr,
   output logic              resp_fault,
   output logic [3:0]        resp_cause,
   output logic              mem_read,
   output logic [PA_W-1:0]   mem_addr,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_resp,
   input  logic              flush,
   input  logic              flush_asid_en,
   input  logic [ASID_W-1:0] flush_asid
);

   localparam int VPNS_W = LEVELS*VPN_W;
   localparam int LVL_W  = (LEVELS > 1) ? $clog2(LEVELS) : 1;
   localparam int IDX_W  = $clog2(TLB_ENTRIES);
   localparam logic [1:0] T_FETCH = 2'b00;
   localparam logic [1:0] T_STORE = 2'b10;

   typedef enum logic [1:0] {IDLE, WALK_REQ, CHECK, RESP} state_t;

   typedef struct packed {
      logic              valid;
      logic [ASID_W-1:0] asid;
      logic              g;
      logic [LVL_W-1:0]  level;
      logic [VPNS_W-1:0] vpn;
      logic [PPN_W-1:0]  ppn;
      logic              u, x, w, r, d;
   } tlb_entry_t;

   // VPN bits that must match for an entry mapped at level lvl
   function automatic logic [VPNS_W-1:0] level_mask(input logic [LVL_W-1:0] lvl);
      logic [VPNS_W-1:0] m;
      for (int b = 0; b < VPNS_W; b++) m[b] = (b / VPN_W) >= int'(lvl);
      return m;
   endfunction

   // PPN bits below level lvl that a superpage leaf must leave zero
   function automatic logic [PPN_W-1:0] low_mask(input logic [LVL_W-1:0] lvl);
      logic [PPN_W-1:0] m;
      for (int b = 0; b < PPN_W; b++) m[b] = b < int'(lvl)*VPN_W;
      return m;
   endfunction

   function automatic logic [PPN_W-1:0] compose_ppn(input logic [PPN_W-1:0] ppn,
         input logic [VPNS_W-1:0] vpn, input logic [LVL_W-1:0] lvl);
      logic [PPN_W-1:0] v;
      logic [PPN_W-1:0] p;
      v = PPN_W'(vpn);
      for (int b = 0; b < PPN_W; b++) p[b] = (b < int'(lvl)*VPN_W) ? v[b] : ppn[b];
      return p;
   endfunction

   function automatic logic perm_ok(input logic [1:0] t, input logic [1:0] e, input logic s,
         input logic m, input logic u, input logic x, input logic w, input logic r,
         input logic d);
      logic ok;
      ok = 1'b1;
      if (e == 2'd0 && !u) ok = 1'b0;
      if (e != 2'd0 && u && (t == T_FETCH || !s)) ok = 1'b0;
      case (t)
         T_FETCH: if (!x) ok = 1'b0;
         T_STORE: if (!w || !d) ok = 1'b0;
         default: if (!(r || (m && x))) ok = 1'b0;
      endcase
      return ok;
   endfunction

   function automatic logic [3:0] cause_of(input logic [1:0] t);
      case (t)
         T_FETCH: return 4'd12;
         T_STORE: return 4'd15;
         default: return 4'd13;
      endcase
   endfunction

   state_t            state, state_n;
   tlb_entry_t        tlb [TLB_ENTRIES];
   logic [VA_W-1:0]   q_vaddr;
   logic [1:0]        q_type, q_eff;
   logic [ASID_W-1:0] q_asid;
   logic [LVL_W-1:0]  lvl;
   logic [PA_W-1:0]   tbl_base;
   logic [31:0]       pte;
   logic              walk_flushed;
   logic [IDX_W-1:0]  rr_ptr;

   // request-side lookup, evaluated against live inputs in IDLE
   logic [1:0]        eff;
   logic              bare, accept;
   logic [VPNS_W-1:0] req_vpn;

   assign eff     = (mprv && req_type != T_FETCH) ? mpp : priv;
   assign bare    = (eff == 2'd3) || !satp_mode;
   assign accept  = req_valid && req_ready;
   assign req_vpn = req_vaddr[VA_W-1:12];

   logic [TLB_ENTRIES-1:0] hit_vec;
   for (genvar e = 0; e < TLB_ENTRIES; e++) begin : g_cmp
      assign hit_vec[e] = tlb[e].valid && (tlb[e].g || tlb[e].asid == satp_asid) &&
                          (((tlb[e].vpn ^ req_vpn) & level_mask(tlb[e].level)) == '0);
   end

   logic             hit_any, hit_u, hit_x, hit_w, hit_r, hit_d, hit_ok;
   logic [LVL_W-1:0] hit_lvl;
   logic [PPN_W-1:0] hit_ppn;
   logic [PA_W-1:0]  hit_pa;

   always_comb begin
      hit_any = 1'b0;
      hit_lvl = '0;
      hit_ppn = '0;
      {hit_u, hit_x, hit_w, hit_r, hit_d} = '0;
      for (int e = 0; e < TLB_ENTRIES; e++) begin
         if (hit_vec[e] && !hit_any) begin
            hit_any = 1'b1;
            hit_lvl = tlb[e].level;
            hit_ppn = tlb[e].ppn;
            {hit_u, hit_x, hit_w, hit_r, hit_d} =
               {tlb[e].u, tlb[e].x, tlb[e].w, tlb[e].r, tlb[e].d};
         end
      end
   end

   assign hit_ok = perm_ok(req_type, eff, sum, mxr, hit_u, hit_x, hit_w, hit_r, hit_d);
   assign hit_pa = {compose_ppn(hit_ppn, req_vpn, hit_lvl), req_vaddr[11:0]};

   // walk-side decode of the registered PTE
   logic [VPNS_W-1:0] q_vpn;
   logic [VPN_W-1:0]  cur_vpn;
   logic [PPN_W-1:0]  pte_ppn;
   logic              pte_bad, pte_ptr, pte_misal, pte_ok, unused_pte;
   logic [PA_W-1:0]   walk_pa;

   assign q_vpn      = q_vaddr[VA_W-1:12];
   assign cur_vpn    = q_vpn[int'(lvl)*VPN_W +: VPN_W];
   assign pte_ppn    = pte[10 +: PPN_W];
   assign pte_bad    = !pte[0] || (!pte[1] && pte[2]);
   assign pte_ptr    = !pte[1] && !pte[3];
   assign pte_misal  = (lvl != '0) && |(pte_ppn & low_mask(lvl));
   assign pte_ok     = pte[6] && perm_ok(q_type, q_eff, sum, mxr,
                                         pte[4], pte[3], pte[2], pte[1], pte[7]);
   assign walk_pa    = {compose_ppn(pte_ppn, q_vpn, lvl), q_vaddr[11:0]};
   assign unused_pte = ^pte;

   assign req_ready  = (state == IDLE);
   assign resp_valid = (state == RESP);
   assign mem_read   = (state == WALK_REQ);
   assign mem_addr   = mem_read ? tbl_base + (PA_W'(cur_vpn) << 2) : '0;

   logic            descend, fill;
   logic [PA_W-1:0] paddr_n;
   logic            fault_n;
   logic [3:0]      cause_n;

   always_comb begin
      state_n = state;
      descend = 1'b0;
      fill    = 1'b0;
      paddr_n = resp_paddr;
      fault_n = resp_fault;
      cause_n = resp_cause;
      case (state)
         IDLE: if (req_valid) begin
            if (bare) begin
               state_n = RESP;
               paddr_n = PA_W'(req_vaddr);
               fault_n = 1'b0;
               cause_n = 4'd0;
            end else if (hit_any) begin
               state_n = RESP;
               paddr_n = hit_ok ? hit_pa : '0;
               fault_n = !hit_ok;
               cause_n = hit_ok ? 4'd0 : cause_of(req_type);
            end else begin
               state_n = WALK_REQ;
            end
         end
         WALK_REQ: if (mem_resp) state_n = CHECK;
         CHECK: begin
            state_n = RESP;
            if (!pte_bad && pte_ptr && lvl != '0) begin
               state_n = WALK_REQ;
               descend = 1'b1;
            end else if (!pte_bad && !pte_ptr && !pte_misal && pte_ok) begin
               paddr_n = walk_pa;
               fault_n = 1'b0;
               cause_n = 4'd0;
               fill    = 1'b1;
            end else begin
               paddr_n = '0;
               fault_n = 1'b1;
               cause_n = cause_of(q_type);
            end
         end
         RESP: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_n;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         resp_paddr   <= '0;
         resp_fault   <= 1'b0;
         resp_cause   <= 4'd0;
         q_vaddr      <= '0;
         q_type       <= 2'b00;
         q_eff        <= 2'b00;
         q_asid       <= '0;
         lvl          <= '0;
         tbl_base     <= '0;
         pte          <= '0;
         walk_flushed <= 1'b0;
      end else begin
         resp_paddr <= paddr_n;
         resp_fault <= fault_n;
         resp_cause <= cause_n;
         if (accept) begin
            q_vaddr      <= req_vaddr;
            q_type       <= req_type;
            q_eff        <= eff;
            q_asid       <= satp_asid;
            lvl          <= LVL_W'(LEVELS-1);
            tbl_base     <= {satp_ppn, 12'b0};
            walk_flushed <= 1'b0;
         end else if (flush && state != IDLE) begin
            walk_flushed <= 1'b1;
         end
         if (state == WALK_REQ && mem_resp) pte <= mem_rdata;
         if (descend) begin
            lvl      <= lvl - LVL_W'(1);
            tbl_base <= {pte_ppn, 12'b0};
         end
      end
   end

   // a walk that saw a flush still answers but never refills stale data
   logic             fill_en, any_inv;
   logic [IDX_W-1:0] victim;
   tlb_entry_t       new_ent;

   assign fill_en = fill && !flush && !walk_flushed;

   always_comb begin
      any_inv = 1'b0;
      victim  = rr_ptr;
      for (int e = 0; e < TLB_ENTRIES; e++) begin
         if (!tlb[e].valid && !any_inv) begin
            any_inv = 1'b1;
            victim  = IDX_W'(e);
         end
      end
   end

   always_comb begin
      new_ent       = '0;
      new_ent.valid = 1'b1;
      new_ent.asid  = q_asid;
      new_ent.g     = pte[5];
      new_ent.level = lvl;
      new_ent.vpn   = q_vpn;
      new_ent.ppn   = pte_ppn;
      new_ent.u     = pte[4];
      new_ent.x     = pte[3];
      new_ent.w     = pte[2];
      new_ent.r     = pte[1];
      new_ent.d     = pte[7];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int e = 0; e < TLB_ENTRIES; e++) tlb[e] <= '0;
         rr_ptr <= '0;
      end else begin
         for (int e = 0; e < TLB_ENTRIES; e++) begin
            if (flush) begin
               if (!flush_asid_en || (tlb[e].asid == flush_asid && !tlb[e].g))
                  tlb[e].valid <= 1'b0;
            end else if (fill_en && victim == IDX_W'(e)) begin
               tlb[e] <= new_ent;
            end
         end
         if (fill_en && !any_inv)
            rr_ptr <= (rr_ptr == IDX_W'(TLB_ENTRIES-1)) ? '0 : rr_ptr + IDX_W'(1);
      end
   end

endmodule
